// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register window byte
// offsets, CTRL/STATUS bit positions and the transmit sequencer states.
package uart_pkg;

  localparam int unsigned CTRL_OFS = 'h0;
  localparam int unsigned STAT_OFS = 'h4;
  localparam int unsigned TXD_OFS  = 'h8;
  localparam int unsigned RXD_OFS  = 'hC;

  localparam int unsigned CTRL_SEND = 0;
  localparam int unsigned CTRL_TXIE = 1;
  localparam int unsigned CTRL_RXIE = 2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_RX_FULL = 1;
  localparam int unsigned STAT_RX_OVR  = 2;
  localparam int unsigned STAT_TX_DONE = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_status_flags.sv
// Sticky UART status flags (RX_FULL, RX_OVR, TX_DONE).
// Each flag has a set and a clear input; set wins when both fire in the same
// cycle. The *_nxt_o outputs expose the next-state values so the parent can
// register derived signals (interrupt) in step with the flags.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   *_set_i / *_clr_i     : per-flag set and clear events
//   rx_full_o ... tx_done_o: current flag values
//   *_nxt_o               : flag values after the coming edge (pre-reset)
module uart_status_flags (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_full_set_i,
  input  logic rx_full_clr_i,
  input  logic rx_ovr_set_i,
  input  logic rx_ovr_clr_i,
  input  logic tx_done_set_i,
  input  logic tx_done_clr_i,
  output logic rx_full_o,
  output logic rx_ovr_o,
  output logic tx_done_o,
  output logic rx_full_nxt_o,
  output logic rx_ovr_nxt_o,
  output logic tx_done_nxt_o
);

  logic rx_full_q, rx_full_d;
  logic rx_ovr_q, rx_ovr_d;
  logic tx_done_q, tx_done_d;

  always_comb begin
    rx_full_d = rx_full_set_i | (rx_full_q & ~rx_full_clr_i);
    rx_ovr_d  = rx_ovr_set_i  | (rx_ovr_q  & ~rx_ovr_clr_i);
    tx_done_d = tx_done_set_i | (tx_done_q & ~tx_done_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_full_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign rx_full_o     = rx_full_q;
  assign rx_ovr_o      = rx_ovr_q;
  assign tx_done_o     = tx_done_q;
  assign rx_full_nxt_o = rx_full_d;
  assign rx_ovr_nxt_o  = rx_ovr_d;
  assign tx_done_nxt_o = tx_done_d;

endmodule

// File: rtl/uart_ctrl.sv
// Bus-side UART controller. Decodes CPU loads/stores to a 4-word register
// window (CTRL, STATUS, TXDATA, RXDATA), sequences the transmitter through
// start/wait/done, captures received bytes and raises a level interrupt.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   addr_i, we_i, re_i, wdata_i : CPU bus access (one-cycle strobes)
//   rdata_o                    : combinational read data for addr_i
//   tx_wr_o, tx_wdata_o, tx_reg_i : TX data register write port / contents
//   rx_wr_o, rx_wdata_o, rx_reg_i : RX data register write port / contents
//   tx_start_o, tx_busy_i, tx_done_i : transmitter handshake
//   rx_valid_i, rx_byte_i      : receiver byte strobe
//   irq_o                      : registered level interrupt
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned AW     = 4,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [W-1:0]      wdata_i,
  output logic [W-1:0]      rdata_o,
  output logic              tx_wr_o,
  output logic [W-1:0]      tx_wdata_o,
  input  logic [W-1:0]      tx_reg_i,
  output logic              rx_wr_o,
  output logic [W-1:0]      rx_wdata_o,
  input  logic [W-1:0]      rx_reg_i,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_byte_i,
  output logic              irq_o
);

  tx_state_t state_q, state_d;
  logic send_q, send_d;
  logic txie_q, txie_d;
  logic rxie_q, rxie_d;
  logic irq_q, irq_d;

  logic [AW-1:0] word_addr;
  logic sel_ctrl, sel_stat, sel_txd, sel_rxd;
  logic ctrl_wr, stat_wr, rx_rd, tx_busy;
  logic rx_full, rx_ovr, tx_done;
  logic rx_full_nxt, rx_ovr_nxt, tx_done_nxt;
  logic tx_done_set, rx_ovr_set;

  // The transmitter busy input is informational only; byte-lane address bits
  // are ignored. Both are collected here so they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, tx_busy_i, addr_i[1:0]};

  assign word_addr = {addr_i[AW-1:2], 2'b00};
  assign sel_ctrl  = (word_addr == AW'(CTRL_OFS));
  assign sel_stat  = (word_addr == AW'(STAT_OFS));
  assign sel_txd   = (word_addr == AW'(TXD_OFS));
  assign sel_rxd   = (word_addr == AW'(RXD_OFS));

  assign ctrl_wr = we_i & sel_ctrl;
  assign stat_wr = we_i & sel_stat;
  assign rx_rd   = re_i & sel_rxd;
  assign tx_busy = (state_q != IDLE);

  // TX register is only writable while no character is in flight.
  assign tx_wr_o    = we_i & sel_txd & ~tx_busy;
  assign tx_wdata_o = wdata_i;

  // A byte arriving while full is accepted only if the old one is being read
  // in the same cycle; otherwise it is dropped and flagged as overrun.
  assign rx_wr_o    = rx_valid_i & (~rx_full | rx_rd);
  assign rx_ovr_set = rx_valid_i & rx_full & ~rx_rd;
  assign rx_wdata_o = {{(W-BYTE_W){1'b0}}, rx_byte_i};

  always_comb begin
    state_d     = state_q;
    send_d      = send_q;
    txie_d      = txie_q;
    rxie_d      = rxie_q;
    tx_start_o  = 1'b0;
    tx_done_set = 1'b0;

    if (ctrl_wr) begin
      txie_d = wdata_i[CTRL_TXIE];
      rxie_d = wdata_i[CTRL_RXIE];
    end

    unique case (state_q)
      IDLE: begin
        if (ctrl_wr && wdata_i[CTRL_SEND]) begin
          send_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_start_o = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_done_i) begin
          state_d     = IDLE;
          send_d      = 1'b0;
          tx_done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Built from next-state values so irq_o always matches the flags it reports.
    irq_d = (txie_d & tx_done_nxt) | (rxie_d & rx_full_nxt) | rx_ovr_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
      txie_q  <= 1'b0;
      rxie_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      txie_q  <= txie_d;
      rxie_q  <= rxie_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;

  uart_status_flags u_flags (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_full_set_i (rx_wr_o),
    .rx_full_clr_i (rx_rd),
    .rx_ovr_set_i  (rx_ovr_set),
    .rx_ovr_clr_i  (stat_wr & wdata_i[STAT_RX_OVR]),
    .tx_done_set_i (tx_done_set),
    .tx_done_clr_i (stat_wr & wdata_i[STAT_TX_DONE]),
    .rx_full_o     (rx_full),
    .rx_ovr_o      (rx_ovr),
    .tx_done_o     (tx_done),
    .rx_full_nxt_o (rx_full_nxt),
    .rx_ovr_nxt_o  (rx_ovr_nxt),
    .tx_done_nxt_o (tx_done_nxt)
  );

  always_comb begin
    rdata_o = '0;
    if (sel_ctrl) begin
      rdata_o[CTRL_SEND] = send_q;
      rdata_o[CTRL_TXIE] = txie_q;
      rdata_o[CTRL_RXIE] = rxie_q;
    end else if (sel_stat) begin
      rdata_o[STAT_BUSY]    = tx_busy;
      rdata_o[STAT_RX_FULL] = rx_full;
      rdata_o[STAT_RX_OVR]  = rx_ovr;
      rdata_o[STAT_TX_DONE] = tx_done;
    end else if (sel_txd) begin
      rdata_o = tx_reg_i;
    end else begin
      rdata_o = rx_reg_i;
    end
  end

endmodule
